// File: rtl/lcd_spi_tx_sched.sv
// SPI mode-0 transmit scheduler for the ILI9341 link: round-robin arbitration between
// command and pixel requesters, one 9-bit word (DC + byte) serialized per grant.
module lcd_spi_tx_sched #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_cmd_valid,
  input  logic [8:0]       i_cmd_data,
  output logic             o_cmd_ready,
  input  logic             i_pix_valid,
  input  logic [8:0]       i_pix_data,
  output logic             o_pix_ready,
  output logic             o_cs_n,
  output logic             o_dc,
  output logic             o_sck,
  output logic             o_mosi,
  output logic             o_busy
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, NEXT} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] h_q, h_d, hcnt_q, hcnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             cs_n_d, sck_d, mosi_d, dc_d;
  logic             rr_pix_q, rr_pix_d;

  logic             can_accept, grant_cmd, grant_pix, accept, h_last;
  logic [8:0]       word;
  logic [DIV_W-1:0] div_eff;

  // rr_pix_q remembers whether the pixel port won the last grant, so a tie goes to the other port
  assign can_accept  = (state_q == IDLE) || (state_q == NEXT);
  assign grant_cmd   = can_accept && i_cmd_valid && (!i_pix_valid || rr_pix_q);
  assign grant_pix   = can_accept && i_pix_valid && (!i_cmd_valid || !rr_pix_q);
  assign accept      = grant_cmd || grant_pix;
  assign word        = grant_cmd ? i_cmd_data : i_pix_data;
  assign o_cmd_ready = grant_cmd;
  assign o_pix_ready = grant_pix;
  assign o_busy      = (state_q != IDLE);

  assign div_eff = (i_div == '0) ? DIV_W'(DEF_DIV) : i_div;
  assign h_last  = (hcnt_q == h_q - DIV_W'(1));

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    hcnt_d   = hcnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    cs_n_d   = o_cs_n;
    sck_d    = o_sck;
    mosi_d   = o_mosi;
    dc_d     = o_dc;
    rr_pix_d = rr_pix_q;

    if (accept) begin
      rr_pix_d = grant_pix;
    end

    case (state_q)
      IDLE, NEXT: begin
        if (accept) begin
          state_d = SETUP;
          h_d     = div_eff;
          hcnt_d  = '0;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          dc_d    = word[8];
          mosi_d  = word[7];
          sh_d    = {word[6:0], 1'b0};
        end else if (state_q == NEXT) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      SETUP: begin
        hcnt_d = hcnt_q + DIV_W'(1);
        if (h_last) begin
          hcnt_d  = '0;
          state_d = SHIFT;
          sck_d   = 1'b1;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        hcnt_d = hcnt_q + DIV_W'(1);
        if (h_last) begin
          hcnt_d = '0;
          if (o_sck) begin
            // Falling edge: present the next bit; the last bit simply stays on the line
            sck_d = 1'b0;
            if (bit_q != 3'd7) begin
              mosi_d = sh_q[7];
              sh_d   = {sh_q[6:0], 1'b0};
            end
          end else begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = HOLD;
            end else begin
              sck_d = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        hcnt_d = hcnt_q + DIV_W'(1);
        if (h_last) begin
          hcnt_d  = '0;
          state_d = NEXT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      h_q      <= DIV_W'(DEF_DIV);
      hcnt_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      o_cs_n   <= 1'b1;
      o_sck    <= 1'b0;
      o_mosi   <= 1'b0;
      o_dc     <= 1'b0;
      rr_pix_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      hcnt_q   <= hcnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      o_cs_n   <= cs_n_d;
      o_sck    <= sck_d;
      o_mosi   <= mosi_d;
      o_dc     <= dc_d;
      rr_pix_q <= rr_pix_d;
    end
  end

endmodule

// File: tb/tb_lcd_spi_tx_sched.sv
// Self-checking bench for lcd_spi_tx_sched: decodes the SPI pins into words and phase
// lengths and compares them with a word-level model of arbitration and timing.
module tb_lcd_spi_tx_sched;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 4;

  logic             i_clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] i_div = '0;
  logic             i_cmd_valid = 1'b0, i_pix_valid = 1'b0;
  logic [8:0]       i_cmd_data = '0, i_pix_data = '0;
  logic             o_cmd_ready, o_pix_ready, o_cs_n, o_dc, o_sck, o_mosi, o_busy;

  lcd_spi_tx_sched #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .i_clk(i_clk), .rst(rst), .i_div(i_div),
    .i_cmd_valid(i_cmd_valid), .i_cmd_data(i_cmd_data), .o_cmd_ready(o_cmd_ready),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
    .o_cs_n(o_cs_n), .o_dc(o_dc), .o_sck(o_sck), .o_mosi(o_mosi), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int   checks = 0, errors = 0;
  bit   model_rr_pix = 1'b1;
  bit   both_rdy_seen = 1'b0;

  // Pin decoder: words captured at SCK rising edges, SCK-high and CS-low run lengths
  logic [8:0] rx_q[$];
  int         hi_q[$];
  int         cs_q[$];
  int         rises = 0, hi_len = 0, cs_len = 0, nbits = 0;
  logic       prev_sck = 1'b0, wdc = 1'b0;
  logic [7:0] bits = '0;

  initial begin
    forever begin
      @(negedge i_clk);
      if (o_sck && !prev_sck) begin
        if (nbits == 0) wdc = o_dc;
        bits = {bits[6:0], o_mosi};
        nbits++;
        rises++;
        if (nbits == 8) begin
          rx_q.push_back({wdc, bits});
          nbits = 0;
        end
      end
      if (o_sck) hi_len++;
      else if (prev_sck) begin
        hi_q.push_back(hi_len);
        hi_len = 0;
      end
      if (!o_cs_n) cs_len++;
      else begin
        if (cs_len > 0) cs_q.push_back(cs_len);
        cs_len = 0;
        nbits  = 0;
      end
      prev_sck = o_sck;
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      #2;
      if (o_cmd_ready && o_pix_ready) both_rdy_seen = 1'b1;
    end
  end

  function automatic bit model_grant_pix(input bit cv, input bit pv, input bit last_pix);
    if (cv && pv) return !last_pix;
    return pv;
  endfunction

  function automatic int model_h(input int div);
    return (div == 0) ? DEF_DIV : div;
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    hi_q.delete();
    cs_q.delete();
  endtask

  task automatic do_accept(input bit cv, input bit pv, input logic [8:0] cd, input logic [8:0] pd,
                           input logic [DIV_W-1:0] div, output bit gp, output bit ok);
    @(negedge i_clk);
    i_cmd_valid = cv; i_pix_valid = pv; i_cmd_data = cd; i_pix_data = pd; i_div = div;
    ok = 1'b0; gp = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      #1;
      if (o_cmd_ready || o_pix_ready) begin
        ok = 1'b1;
        gp = o_pix_ready;
      end
      @(negedge i_clk);
    end
    i_cmd_valid = 1'b0; i_pix_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge i_clk);
      #1;
      if (!o_busy) ok = 1'b1;
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (o_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n: got %b want 1", o_cs_n); end
    checks++; if (o_sck !== 1'b0) begin errors++; $display("[TB] FAIL reset_sck: got %b want 0", o_sck); end
    checks++; if (o_mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi: got %b want 0", o_mosi); end
    checks++; if (o_dc !== 1'b0) begin errors++; $display("[TB] FAIL reset_dc: got %b want 0", o_dc); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if ({o_cmd_ready, o_pix_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b want 00", {o_cmd_ready, o_pix_ready}); end
    rst = 1'b0;
    model_rr_pix = 1'b1;
    repeat (2) @(negedge i_clk);
    clear_mon();
  endtask

  task automatic test_single_cmd();
    bit gp, ok, idle, exp;
    int bad;
    clear_mon();
    do_accept(1'b1, 1'b0, 9'h02A, 9'h000, 8'd2, gp, ok);
    exp = model_grant_pix(1'b1, 1'b0, model_rr_pix); model_rr_pix = exp;
    checks++; if (!ok || gp !== exp) begin errors++; $display("[TB] FAIL single_grant: got ok=%b pix=%b want ok=1 pix=%b", ok, gp, exp); end
    checks++; if (o_cs_n !== 1'b0 || o_dc !== 1'b0) begin errors++; $display("[TB] FAIL single_cs_dc: got cs_n=%b dc=%b want 0 0", o_cs_n, o_dc); end
    wait_idle(idle);
    checks++; if (!idle) begin errors++; $display("[TB] FAIL single_idle: got busy timeout want idle"); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 9'h02A) begin errors++; $display("[TB] FAIL single_word: got n=%0d w=%h want n=1 w=02a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0); end
    bad = 0; foreach (hi_q[i]) if (hi_q[i] != 2) bad++;
    checks++; if (hi_q.size() != 8 || bad != 0) begin errors++; $display("[TB] FAIL single_sck_high: got pulses=%0d bad=%0d want 8 pulses of 2", hi_q.size(), bad); end
    checks++; if (cs_q.size() != 1 || cs_q[0] != 18 * 2 + 1) begin errors++; $display("[TB] FAIL single_cs_len: got n=%0d len=%0d want n=1 len=%0d", cs_q.size(), (cs_q.size() > 0) ? cs_q[0] : 0, 18 * 2 + 1); end
    checks++; if (o_cs_n !== 1'b1 || o_mosi !== 1'b0) begin errors++; $display("[TB] FAIL single_end: got cs_n=%b mosi=%b want 1 0", o_cs_n, o_mosi); end
  endtask

  task automatic test_div_zero();
    bit gp, ok, idle, exp;
    int bad;
    clear_mon();
    do_accept(1'b0, 1'b1, 9'h000, 9'h1FF, 8'd0, gp, ok);
    exp = model_grant_pix(1'b0, 1'b1, model_rr_pix); model_rr_pix = exp;
    checks++; if (!ok || gp !== exp) begin errors++; $display("[TB] FAIL div0_grant: got ok=%b pix=%b want ok=1 pix=%b", ok, gp, exp); end
    wait_idle(idle);
    checks++; if (!idle) begin errors++; $display("[TB] FAIL div0_idle: got busy timeout want idle"); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 9'h1FF) begin errors++; $display("[TB] FAIL div0_word: got n=%0d w=%h want n=1 w=1ff", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0); end
    bad = 0; foreach (hi_q[i]) if (hi_q[i] != DEF_DIV) bad++;
    checks++; if (hi_q.size() != 8 || bad != 0) begin errors++; $display("[TB] FAIL div0_sck_high: got pulses=%0d bad=%0d want 8 pulses of %0d", hi_q.size(), bad, DEF_DIV); end
    checks++; if (cs_q.size() != 1 || cs_q[0] != 18 * DEF_DIV + 1) begin errors++; $display("[TB] FAIL div0_cs_len: got n=%0d len=%0d want %0d", cs_q.size(), (cs_q.size() > 0) ? cs_q[0] : 0, 18 * DEF_DIV + 1); end
  endtask

  task automatic test_contention();
    bit got[4];
    bit exp, idle;
    int acc, h, bad;
    logic [8:0] exp_w[4];
    clear_mon();
    both_rdy_seen = 1'b0;
    h = $urandom_range(1, 3);
    @(negedge i_clk);
    i_cmd_valid = 1'b1; i_pix_valid = 1'b1; i_cmd_data = 9'h0AA; i_pix_data = 9'h155; i_div = DIV_W'(h);
    acc = 0;
    for (int n = 0; n < 4000 && acc < 4; n++) begin
      #1;
      if (o_cmd_ready || o_pix_ready) begin
        got[acc] = o_pix_ready;
        acc++;
      end
      @(negedge i_clk);
    end
    i_cmd_valid = 1'b0; i_pix_valid = 1'b0;
    checks++; if (acc != 4) begin errors++; $display("[TB] FAIL cont_accepts: got %0d want 4", acc); end
    for (int k = 0; k < 4; k++) begin
      exp = model_grant_pix(1'b1, 1'b1, model_rr_pix); model_rr_pix = exp;
      exp_w[k] = exp ? 9'h155 : 9'h0AA;
      checks++; if (got[k] !== exp) begin errors++; $display("[TB] FAIL cont_grant%0d: got pix=%b want pix=%b", k, got[k], exp); end
    end
    wait_idle(idle);
    checks++; if (!idle) begin errors++; $display("[TB] FAIL cont_idle: got busy timeout want idle"); end
    bad = 0; for (int k = 0; k < 4; k++) if (k >= rx_q.size() || rx_q[k] !== exp_w[k]) bad++;
    checks++; if (rx_q.size() != 4 || bad != 0) begin errors++; $display("[TB] FAIL cont_words: got n=%0d bad=%0d want n=4 bad=0", rx_q.size(), bad); end
    bad = 0; foreach (hi_q[i]) if (hi_q[i] != h) bad++;
    checks++; if (hi_q.size() != 32 || bad != 0) begin errors++; $display("[TB] FAIL cont_sck_high: got pulses=%0d bad=%0d want 32 of %0d", hi_q.size(), bad, h); end
    checks++; if (cs_q.size() != 1 || cs_q[0] != 4 * (18 * h + 1)) begin errors++; $display("[TB] FAIL cont_cs_len: got n=%0d len=%0d want n=1 len=%0d", cs_q.size(), (cs_q.size() > 0) ? cs_q[0] : 0, 4 * (18 * h + 1)); end
    checks++; if (both_rdy_seen) begin errors++; $display("[TB] FAIL cont_both_ready: got 1 want 0"); end
  endtask

  task automatic test_div_change();
    bit gp, ok, idle, exp;
    int bad;
    logic [8:0] w1, w2;
    clear_mon();
    w1 = 9'($urandom);
    w2 = 9'($urandom);
    do_accept(1'b1, 1'b0, w1, 9'h000, 8'd3, gp, ok);
    exp = model_grant_pix(1'b1, 1'b0, model_rr_pix); model_rr_pix = exp;
    checks++; if (!ok || gp !== exp) begin errors++; $display("[TB] FAIL divchg_grant: got ok=%b pix=%b want ok=1 pix=%b", ok, gp, exp); end
    for (int n = 0; n < 100 && !o_sck; n++) @(negedge i_clk);
    i_div = 8'd1;
    wait_idle(idle);
    bad = 0; foreach (hi_q[i]) if (hi_q[i] != 3) bad++;
    checks++; if (!idle || hi_q.size() != 8 || bad != 0) begin errors++; $display("[TB] FAIL divchg_first_h: got idle=%b pulses=%0d bad=%0d want 8 of 3", idle, hi_q.size(), bad); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== w1 || cs_q.size() != 1 || cs_q[0] != 55) begin errors++; $display("[TB] FAIL divchg_first_word: got w=%h cs=%0d want w=%h cs=55", (rx_q.size() > 0) ? rx_q[0] : 9'h0, (cs_q.size() > 0) ? cs_q[0] : 0, w1); end
    clear_mon();
    do_accept(1'b0, 1'b1, 9'h000, w2, 8'd1, gp, ok);
    exp = model_grant_pix(1'b0, 1'b1, model_rr_pix); model_rr_pix = exp;
    wait_idle(idle);
    bad = 0; foreach (hi_q[i]) if (hi_q[i] != 1) bad++;
    checks++; if (!ok || !idle || hi_q.size() != 8 || bad != 0) begin errors++; $display("[TB] FAIL divchg_second_h: got ok=%b pulses=%0d bad=%0d want 8 of 1", ok, hi_q.size(), bad); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== w2 || cs_q.size() != 1 || cs_q[0] != 19) begin errors++; $display("[TB] FAIL divchg_second_word: got w=%h cs=%0d want w=%h cs=19", (rx_q.size() > 0) ? rx_q[0] : 9'h0, (cs_q.size() > 0) ? cs_q[0] : 0, w2); end
  endtask

  task automatic test_reset_mid();
    bit gp, ok, idle, exp, found;
    int r0, h, bad;
    clear_mon();
    do_accept(1'b1, 1'b0, 9'($urandom), 9'h000, 8'd2, gp, ok);
    exp = model_grant_pix(1'b1, 1'b0, model_rr_pix); model_rr_pix = exp;
    r0 = rises - ((o_sck && !prev_sck) ? 1 : 0);
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      #1;
      if (rises - r0 >= 4) found = 1'b1;
      else @(negedge i_clk);
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rstmid_fourth_rise: got timeout want 4 rises"); end
    rst = 1'b1;
    @(negedge i_clk);
    #1;
    checks++; if (o_cs_n !== 1'b1 || o_sck !== 1'b0 || o_busy !== 1'b0 || o_mosi !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_abort: got cs_n=%b sck=%b busy=%b mosi=%b want 1 0 0 0", o_cs_n, o_sck, o_busy, o_mosi); end
    rst = 1'b0;
    model_rr_pix = 1'b1;
    @(negedge i_clk);
    clear_mon();
    h = $urandom_range(1, 4);
    do_accept(1'b1, 1'b0, 9'h0C3, 9'h000, DIV_W'(h), gp, ok);
    exp = model_grant_pix(1'b1, 1'b0, model_rr_pix); model_rr_pix = exp;
    wait_idle(idle);
    checks++; if (!ok || !idle || rx_q.size() != 1 || rx_q[0] !== 9'h0C3) begin errors++; $display("[TB] FAIL rstmid_word: got n=%0d w=%h want n=1 w=0c3", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0); end
    bad = 0; foreach (hi_q[i]) if (hi_q[i] != h) bad++;
    checks++; if (hi_q.size() != 8 || bad != 0 || cs_q.size() != 1 || cs_q[0] != 18 * h + 1) begin errors++; $display("[TB] FAIL rstmid_timing: got pulses=%0d bad=%0d cs=%0d want 8 of %0d cs=%0d", hi_q.size(), bad, (cs_q.size() > 0) ? cs_q[0] : 0, h, 18 * h + 1); end
  endtask

  task automatic test_random();
    bit gp, ok, idle, exp, cv, pv;
    int sel, div, h, bad;
    logic [8:0] cd, pd, w;
    for (int it = 0; it < 8; it++) begin
      clear_mon();
      sel = $urandom_range(0, 2);
      cv = (sel != 1); pv = (sel != 0);
      cd = 9'($urandom); pd = 9'($urandom);
      div = $urandom_range(0, 3);
      h = model_h(div);
      do_accept(cv, pv, cd, pd, DIV_W'(div), gp, ok);
      exp = model_grant_pix(cv, pv, model_rr_pix); model_rr_pix = exp;
      w = exp ? pd : cd;
      checks++; if (!ok || gp !== exp) begin errors++; $display("[TB] FAIL rand%0d_grant: got ok=%b pix=%b want ok=1 pix=%b", it, ok, gp, exp); end
      wait_idle(idle);
      checks++; if (!idle || rx_q.size() != 1 || rx_q[0] !== w) begin errors++; $display("[TB] FAIL rand%0d_word: got n=%0d w=%h want n=1 w=%h", it, rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0, w); end
      bad = 0; foreach (hi_q[i]) if (hi_q[i] != h) bad++;
      checks++; if (hi_q.size() != 8 || bad != 0 || cs_q.size() != 1 || cs_q[0] != 18 * h + 1) begin errors++; $display("[TB] FAIL rand%0d_timing: got pulses=%0d bad=%0d cs=%0d want 8 of %0d cs=%0d", it, hi_q.size(), bad, (cs_q.size() > 0) ? cs_q[0] : 0, h, 18 * h + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_div_zero();
    test_contention();
    test_div_change();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
